fifo_access_ctrl: RTL and testbench
===================================

// Module: fifo_access_ctrl
// PURPOSE
//   Scheduler that shares one 8x32 FIFObuffer between N_REQ write requesters and one read consumer.
//   The buffer accepts one operation per clock, so this block issues at most one RD or WR per cycle.
//   It keeps its own occupancy count and publishes empty/full/level; the buffer's flags are not used.
//   It also owns the buffer's EN/Rst: an init clear after reset, and a flush on request.
// PARAMETERS
//   N_REQ  4   number of write requesters (2..8)
//   DW     32  data width; must match the FIFO data width
//   DEPTH  8   FIFO entries
//   LW     4   level width = clog2(DEPTH+1)
// PORTS
//   Clk       in   1         clock; all state updates on posedge
//   Rst       in   1         asynchronous, active-high reset
//   wr_req    in   N_REQ     requester i holds a word; held high with wr_data stable until granted
//   wr_data   in   N_REQ*DW  flat; slice i = wr_data[i*DW +: DW]
//   wr_gnt    out  N_REQ     one-hot, 1-cycle pulse: word from slice i was issued to the FIFO
//   rd_req    in   1         level; consumer wants words and must accept every rd_valid
//   rd_valid  out  1         rd_data valid this cycle
//   rd_data   out  DW        word read from the FIFO (= fifo_dout)
//   flush     in   1         1-cycle pulse: discard FIFO contents
//   empty     out  1         level==0
//   full      out  1         level==DEPTH
//   level     out  LW        entries held, counting ops already issued
//   fifo_en   out  1         to FIFO EN
//   fifo_rst  out  1         to FIFO Rst (synchronous clear of FIFO pointers)
//   fifo_wr   out  1         to FIFO WR
//   fifo_rd   out  1         to FIFO RD
//   fifo_din  out  DW        to FIFO dataIn
//   fifo_dout in   DW        from FIFO dataOut
// BEHAVIOUR
//   Reset values: state=INIT, fifo_en=0, fifo_rst=0, fifo_wr=0, fifo_rd=0, fifo_din=0, wr_gnt=0,
//     rd_valid=0, level=0, empty=1, full=0, rr_ptr=0, last_op=RD.
//   All outputs are registered except rd_data, empty and full, which are decoded from registers.
//   FSM
//     INIT  : one cycle with fifo_en=1, fifo_rst=1 -> RUN.
//     RUN   : fifo_en=1; schedule one op per cycle (rules below).
//               flush=1 -> FLUSH; flush takes precedence over any op that cycle.
//     FLUSH : one cycle with fifo_rst=1; level<=0; no grants -> RUN.
//   Scheduling in RUN (decision in cycle T, registered effect at edge T+1):
//     can_rd = rd_req && level!=0
//     can_wr = |(wr_req & ~wr_gnt) && level!=DEPTH   (requester granted this cycle is masked)
//     Both true: level==DEPTH-1 -> RD; otherwise alternate, opposite of last_op.
//     WR: winner is the next requester round-robin from rr_ptr.
//         fifo_wr=1, fifo_din=slice, wr_gnt[winner]=1, rr_ptr<=winner+1 (mod N_REQ), level+1.
//     RD: fifo_rd=1, level-1.
//     Exactly one op or none per cycle; last_op updates only when an op issues.
//   Read latency: FIFO samples fifo_rd at edge T+2 and dataOut becomes valid after it.
//     rd_valid is therefore a copy of fifo_rd delayed one cycle.
//   A read issued before a flush still yields its rd_valid, because the FIFO does not clear dataOut.
//   level saturates by construction: a WR never issues at DEPTH, an RD never issues at 0.
//     Pointer wrap is handled inside the FIFO.
//   Rst asserted mid-operation: everything returns to the reset values immediately;
//     INIT re-clears the FIFO after Rst is released.
// STRUCTURE
//   Package fifo_ctrl_pkg: state enum {INIT,RUN,FLUSH}, op enum {OP_RD,OP_WR}, DEPTH/DW defaults.
//   Sub-module rr_arbiter #(N_REQ): req, mask, ptr -> one-hot gnt and index; purely combinational.
// TESTING
//   1 Reset release -> fifo_rst=1 exactly one cycle, then fifo_en=1, level=0, empty=1.
//   2 wr_req=4'b1111 held, rd_req=0 -> grants in order 0,1,2,3,0,1,2,3.
//       level steps 1..8; full=1; no fifo_wr at level 8.
//   3 Write 0xA0..0xA7, then rd_req=1 -> rd_valid 8 times with 0xA0..0xA7 in order;
//       fifo_rd stops at level 0; empty=1.
//   4 level=4, wr_req=0001 and rd_req held -> ops alternate WR,RD,WR,RD; level oscillates 4/5.
//   5 level=7, wr_req and rd_req both set -> RD chosen; level=6.
//   6 flush at level=5 with a read in flight -> rd_valid still pulses once;
//       fifo_rst 1 cycle; level=0; next write lands at FIFO slot 0.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and defaults for the FIFO access scheduler.
package fifo_ctrl_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned DEPTH_DEF = 8;

  typedef enum logic [1:0] {INIT, RUN, FLUSH} state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;

  // Index width for n requesters; never zero so single-bit pointers stay legal.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after ptr.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    idx,
  output logic             any
);

  logic [N_REQ-1:0] elig;

  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return PW'(s);
  endfunction

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    elig = req & ~mask;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!any && elig[wrap(ptr, k)]) begin
        any = 1'b1;
        idx = wrap(ptr, k);
        gnt[wrap(ptr, k)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_access_ctrl.sv
// Shares one FIFO buffer between N_REQ writers and a single reader, one op per clock,
// tracking occupancy locally and owning the buffer's enable and clear.
module fifo_access_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned LW    = $clog2(DEPTH + 1)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [N_REQ-1:0]   wr_req,
  input  logic [N_REQ*DW-1:0] wr_data,
  output logic [N_REQ-1:0]   wr_gnt,
  input  logic               rd_req,
  output logic               rd_valid,
  output logic [DW-1:0]      rd_data,
  input  logic               flush,
  output logic               empty,
  output logic               full,
  output logic [LW-1:0]      level,
  output logic               fifo_en,
  output logic               fifo_rst,
  output logic               fifo_wr,
  output logic               fifo_rd,
  output logic [DW-1:0]      fifo_din,
  input  logic [DW-1:0]      fifo_dout
);

  localparam int unsigned PW = idx_w(N_REQ);
  localparam logic [LW-1:0] LVL_FULL   = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ALMOST = LW'(DEPTH - 1);

  state_t           state;
  op_t              last_op;
  logic [PW-1:0]    rr_ptr;
  logic [N_REQ-1:0] arb_gnt;
  logic [PW-1:0]    arb_idx;
  logic             arb_any;
  logic [PW-1:0]    next_ptr;
  logic [DW-1:0]    win_data;
  logic             can_rd;
  logic             can_wr;
  logic             do_rd;
  logic             do_wr;

  // A requester granted last cycle still shows wr_req this cycle, so it is masked out.
  rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
    .req  (wr_req),
    .mask (wr_gnt),
    .ptr  (rr_ptr),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  assign win_data = wr_data[32'(arb_idx) * DW +: DW];
  assign next_ptr = (arb_idx == PW'(N_REQ - 1)) ? '0 : arb_idx + PW'(1);

  assign can_rd = rd_req && (level != '0);
  assign can_wr = arb_any && (level != LVL_FULL);

  // Contended cycles alternate, except one-below-full drains first to keep writes flowing.
  always_comb begin
    do_rd = 1'b0;
    do_wr = 1'b0;
    if (state == RUN && !flush) begin
      if (can_rd && can_wr) begin
        if (level == LVL_ALMOST || last_op == OP_WR) do_rd = 1'b1;
        else                                         do_wr = 1'b1;
      end else begin
        do_rd = can_rd;
        do_wr = can_wr;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= INIT;
      last_op  <= OP_RD;
      rr_ptr   <= '0;
      level    <= '0;
      wr_gnt   <= '0;
      rd_valid <= 1'b0;
      fifo_en  <= 1'b0;
      fifo_rst <= 1'b0;
      fifo_wr  <= 1'b0;
      fifo_rd  <= 1'b0;
      fifo_din <= '0;
    end else begin
      wr_gnt   <= '0;
      fifo_wr  <= 1'b0;
      fifo_rd  <= 1'b0;
      fifo_rst <= 1'b0;
      rd_valid <= fifo_rd;
      case (state)
        INIT: begin
          fifo_en  <= 1'b1;
          fifo_rst <= 1'b1;
          state    <= RUN;
        end
        RUN: begin
          fifo_en <= 1'b1;
          if (flush) begin
            state <= FLUSH;
          end else if (do_wr) begin
            fifo_wr  <= 1'b1;
            fifo_din <= win_data;
            wr_gnt   <= arb_gnt;
            rr_ptr   <= next_ptr;
            level    <= level + LW'(1);
            last_op  <= OP_WR;
          end else if (do_rd) begin
            fifo_rd <= 1'b1;
            level   <= level - LW'(1);
            last_op <= OP_RD;
          end
        end
        FLUSH: begin
          fifo_en  <= 1'b1;
          fifo_rst <= 1'b1;
          level    <= '0;
          state    <= RUN;
        end
        default: state <= INIT;
      endcase
    end
  end

  assign empty   = (level == '0);
  assign full    = (level == LVL_FULL);
  assign rd_data = fifo_dout;

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Bench for fifo_access_ctrl: behavioural FIFO stub, per-requester word queues and a read scoreboard.
module tb_fifo_access_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [N-1:0]  wr_req;
  logic [N*DW-1:0] wr_data;
  logic [N-1:0]  wr_gnt;
  logic          rd_req;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          flush;
  logic          empty;
  logic          full;
  logic [3:0]    level;
  logic          fifo_en;
  logic          fifo_rst;
  logic          fifo_wr;
  logic          fifo_rd;
  logic [DW-1:0] fifo_din;
  logic [DW-1:0] fifo_dout = '0;

  fifo_access_ctrl dut (
    .Clk(Clk), .Rst(Rst), .wr_req(wr_req), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .flush(flush),
    .empty(empty), .full(full), .level(level), .fifo_en(fifo_en), .fifo_rst(fifo_rst),
    .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_din(fifo_din), .fifo_dout(fifo_dout)
  );

  always #5 Clk = ~Clk;

  // Buffer stub: 8x32, synchronous clear, registered dataOut, pointers start off zero.
  logic [DW-1:0] tb_mem [8];
  logic [2:0]    tb_wp = 3'd3;
  logic [2:0]    tb_rp = 3'd3;
  int            tb_cnt = 0;

  always @(posedge Clk) begin
    if (fifo_en) begin
      if (fifo_rst) begin
        tb_wp  <= 3'd0;
        tb_rp  <= 3'd0;
        tb_cnt <= 0;
      end else begin
        if (fifo_wr) begin
          tb_mem[tb_wp] <= fifo_din;
          tb_wp <= tb_wp + 3'd1;
        end
        if (fifo_rd) begin
          fifo_dout <= tb_mem[tb_rp];
          tb_rp <= tb_rp + 3'd1;
        end
        tb_cnt <= tb_cnt + int'(fifo_wr) - int'(fifo_rd);
      end
    end
  end

  int            n_checks = 0;
  int            n_errs   = 0;
  logic [DW-1:0] rq_mem [N][32];
  int            rq_head [N];
  int            rq_tail [N];
  logic [DW-1:0] sb [$];
  int            gnt_idx;
  int            rd_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      wr_req[i] = (rq_head[i] != rq_tail[i]);
      wr_data[i*DW +: DW] = rq_mem[i][rq_head[i]];
    end
  endtask

  task automatic push(input int r, input logic [DW-1:0] w);
    rq_mem[r][rq_tail[r]] = w;
    rq_tail[r]++;
    drive_reqs();
  endtask

  // Grant and read-data monitor; runs once per cycle after the outputs settle.
  task automatic observe();
    gnt_idx = -1;
    if (wr_gnt != '0) begin
      check("gnt_onehot", 32'($countones(wr_gnt)), 1);
      check("gnt_wr", 32'(fifo_wr), 1);
      for (int i = 0; i < N; i++) begin
        if (wr_gnt[i]) begin
          gnt_idx = i;
          if (rq_head[i] == rq_tail[i]) begin
            check("gnt_idle", 1, 0);
          end else begin
            check("gnt_din", fifo_din, rq_mem[i][rq_head[i]]);
            sb.push_back(rq_mem[i][rq_head[i]]);
            rq_head[i]++;
          end
        end
      end
    end
    if (fifo_wr && fifo_rd) check("one_op", 1, 0);
    if (fifo_wr) check("no_ovf", 32'(tb_cnt < 8), 1);
    if (fifo_rd) check("no_unf", 32'(tb_cnt > 0), 1);
    if (rd_valid) begin
      rd_cnt++;
      if (sb.size() == 0) check("rd_unexp", 1, 0);
      else check("rd_data", rd_data, sb.pop_front());
    end
    drive_reqs();
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    observe();
  endtask

  initial begin
    int k;
    int rd_before;
    Rst = 1'b1; rd_req = 1'b0; flush = 1'b0; wr_req = '0; wr_data = '0;
    for (int i = 0; i < N; i++) begin
      rq_head[i] = 0;
      rq_tail[i] = 0;
      for (int j = 0; j < 32; j++) rq_mem[i][j] = '0;
    end
    drive_reqs();

    // Reset state and the single-cycle init clear
    step(); step();
    check("rst_en", 32'(fifo_en), 0);
    check("rst_frst", 32'(fifo_rst), 0);
    check("rst_level", 32'(level), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    Rst = 1'b0;
    step();
    check("init_rst", 32'(fifo_rst), 1);
    check("init_en", 32'(fifo_en), 1);
    step();
    check("init_rst_off", 32'(fifo_rst), 0);
    check("init_en_hold", 32'(fifo_en), 1);
    check("init_empty", 32'(empty), 1);
    check("init_ptr", 32'(tb_wp), 0);

    // All four requesters pending: round-robin fill to full
    for (int i = 0; i < N; i++) begin
      push(i, 32'hA0 + 32'(i));
      push(i, 32'hA4 + 32'(i));
      push(i, 32'hA8 + 32'(i));
    end
    k = 0;
    for (int c = 0; c < 60 && k < 8; c++) begin
      step();
      if (gnt_idx >= 0) begin
        check("fill_order", 32'(gnt_idx), 32'(k % 4));
        check("fill_level", 32'(level), 32'(k + 1));
        k++;
      end
    end
    check("fill_count", 32'(k), 8);
    for (int c = 0; c < 3; c++) begin
      step();
      check("full_nowr", 32'(fifo_wr), 0);
      check("full_level", 32'(level), 8);
      check("full_flag", 32'(full), 1);
    end

    // Drain everything in write order
    rd_req = 1'b1;
    for (int c = 0; c < 100 && rd_cnt < 12; c++) step();
    check("drain_count", 32'(rd_cnt), 12);
    for (int c = 0; c < 3; c++) begin
      step();
      check("drain_nord", 32'(fifo_rd), 0);
      check("drain_empty", 32'(empty), 1);
    end
    rd_req = 1'b0;

    // Level 4 with one writer and reader active: strict alternation
    for (int i = 0; i < 5; i++) push(0, 32'hB0 + 32'(i));
    for (int c = 0; c < 40 && !(level == 4'd5 && rq_head[0] == rq_tail[0]); c++) step();
    check("alt_setup", 32'(level), 5);
    rd_req = 1'b1;
    step();
    check("alt_pre_rd", 32'(fifo_rd), 1);
    check("alt_pre_lvl", 32'(level), 4);
    for (int i = 0; i < 4; i++) push(0, 32'hC0 + 32'(i));
    for (int c = 0; c < 8; c++) begin
      step();
      check("alt_op", {30'd0, fifo_wr, fifo_rd}, (c % 2 == 0) ? 32'd2 : 32'd1);
      check("alt_level", 32'(level), (c % 2 == 0) ? 32'd5 : 32'd4);
    end
    rd_req = 1'b0;

    // One below full with both sides pending: read wins
    for (int i = 0; i < 3; i++) push(0, 32'hE0 + 32'(i));
    for (int c = 0; c < 30 && level != 4'd7; c++) step();
    check("almost_setup", 32'(level), 7);
    push(1, 32'hF0);
    rd_req = 1'b1;
    step();
    check("almost_rd", {30'd0, fifo_wr, fifo_rd}, 1);
    check("almost_level", 32'(level), 6);
    rd_req = 1'b0;
    for (int c = 0; c < 10 && rq_head[1] != rq_tail[1]; c++) step();
    step();
    check("almost_refill", 32'(level), 7);

    // Flush at level 5 with a read in flight
    rd_req = 1'b1;
    step();
    check("fl_rd1", 32'(fifo_rd), 1);
    step();
    check("fl_rd2", 32'(fifo_rd), 1);
    check("fl_level5", 32'(level), 5);
    rd_before = rd_cnt;
    flush = 1'b1; rd_req = 1'b0;
    step();
    flush = 1'b0;
    check("fl_noop", {28'd0, wr_gnt}, 0);
    check("fl_noop_op", {30'd0, fifo_wr, fifo_rd}, 0);
    check("fl_inflight", 32'(rd_valid), 1);
    step();
    check("fl_rst", 32'(fifo_rst), 1);
    check("fl_level0", 32'(level), 0);
    check("fl_empty", 32'(empty), 1);
    sb.delete();
    step();
    check("fl_rst_off", 32'(fifo_rst), 0);
    check("fl_ptr", {26'd0, tb_wp, tb_rp}, 0);
    check("fl_rdcount", 32'(rd_cnt), 32'(rd_before + 1));
    push(2, 32'hD0);
    for (int c = 0; c < 10 && gnt_idx != 2; c++) step();
    check("fl_wgnt", 32'(gnt_idx), 2);
    step();
    check("fl_slot0", tb_mem[0], 32'hD0);
    check("fl_wp", 32'(tb_wp), 1);
    rd_req = 1'b1;
    for (int c = 0; c < 10 && rd_cnt < rd_before + 2; c++) step();
    rd_req = 1'b0;
    check("fl_readback", 32'(rd_cnt), 32'(rd_before + 2));
    check("sb_empty", 32'(sb.size()), 0);

    // Reset in the middle of traffic, then init clear again
    push(3, 32'h11); push(3, 32'h22);
    for (int c = 0; c < 20 && level != 4'd2; c++) step();
    check("mid_setup", 32'(level), 2);
    Rst = 1'b1;
    #1;
    check("mid_level", 32'(level), 0);
    check("mid_en", 32'(fifo_en), 0);
    check("mid_empty", 32'(empty), 1);
    sb.delete();
    step();
    Rst = 1'b0;
    step();
    check("mid_init_rst", 32'(fifo_rst), 1);
    step();
    check("mid_init_off", 32'(fifo_rst), 0);
    check("mid_ptr", 32'(tb_wp), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
